// File: rtl/rgb_pixel_packer.sv
// Byte-serial R,G,B to 24-bit pixel packer with a small pixel FIFO and per-frame last tagging.
// Optional PIX_CHECKSUM_EN adds frame_sum, the modulo-2^32 sum of all bytes accepted in the frame.
module rgb_pixel_packer #(
  parameter int NUM_PIXELS = 4096,
  parameter int FIFO_DEPTH = 4,
  parameter int BYTE_W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                sin_valid,
  input  logic [BYTE_W-1:0]   sin,
  output logic                sin_ready,
  output logic                pix_valid,
  output logic [3*BYTE_W-1:0] pix_data,
  output logic                pix_last,
  input  logic                pix_ready,
  output logic                busy,
`ifdef PIX_CHECKSUM_EN
  output logic [31:0]         frame_sum,
`endif
  output logic                frame_done
);

  localparam int CNT_W = $clog2(NUM_PIXELS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int PIX_W = 3 * BYTE_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          phase_q, phase_d;
  logic [BYTE_W-1:0]   r_q, r_d;
  logic [BYTE_W-1:0]   g_q, g_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic                done_q, done_d;

  logic [PIX_W-1:0]    mem_data_q [FIFO_DEPTH];
  logic                mem_last_q [FIFO_DEPTH];

  logic fifo_full;
  logic accept;
  logic push;
  logic pop;
  logic push_last;

  assign fifo_full  = (occ_q == OCC_W'(FIFO_DEPTH));
  assign pix_valid  = (occ_q != '0);
  assign pix_data   = pix_valid ? mem_data_q[rd_ptr_q] : '0;
  assign pix_last   = pix_valid & mem_last_q[rd_ptr_q];
  assign busy       = (state_q != S_IDLE);
  assign frame_done = done_q;

  // Full check uses registered occupancy only: a pop in the same cycle does not make room.
  assign sin_ready  = (state_q == S_RUN) && !((phase_q == 2'd2) && fifo_full);
  assign accept     = sin_valid & sin_ready;
  assign push       = accept && (phase_q == 2'd2);
  assign pop        = pix_valid & pix_ready;
  assign push_last  = (cnt_q == CNT_W'(NUM_PIXELS - 1));

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    r_d     = r_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          phase_d = '0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          unique case (phase_q)
            2'd0: begin
              r_d     = sin;
              phase_d = 2'd1;
            end
            2'd1: begin
              g_d     = sin;
              phase_d = 2'd2;
            end
            default: begin
              phase_d = '0;
              cnt_d   = cnt_q + 1'b1;
              if (push_last) state_d = S_DRAIN;
            end
          endcase
        end
      end
      S_DRAIN: begin
        if (pop && pix_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      r_q      <= '0;
      g_q      <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      r_q      <= r_d;
      g_q      <= g_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      done_q   <= done_d;
    end
  end

  // Storage needs no reset: outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= {r_q, g_q, sin};
      mem_last_q[wr_ptr_q] <= push_last;
    end
  end

`ifdef PIX_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (state_q == S_IDLE && start) sum_d = '0;
    else if (accept)                 sum_d = sum_q + 32'(sin);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign frame_sum = sum_q;
`endif

endmodule
